// File: rtl/keyboard_move_decoder_pkg.sv
// Shared PS/2 set-2 scan codes and state types for the keyboard move decoder.
package kbd_pkg;

  localparam logic [7:0] KC_E0    = 8'hE0;
  localparam logic [7:0] KC_F0    = 8'hF0;
  localparam logic [7:0] KC_RIGHT = 8'h74;
  localparam logic [7:0] KC_LEFT  = 8'h6B;
  localparam logic [7:0] KC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } kbd_state_t;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } dir_t;

endpackage

// File: rtl/keyboard_move_decoder.sv
// Turns PS/2 scan-code bytes into held left/right move levels and a fire pulse,
// with most-recent-direction arbitration and space auto-repeat suppression.
module keyboard_move_decoder
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic       RightMove,
  output logic       LeftMove,
  output logic       FirePulse
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  kbd_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             rightHeld, rightHeld_nx;
  logic             leftHeld, leftHeld_nx;
  logic             spaceHeld, spaceHeld_nx;
  dir_t             lastDir, lastDir_nx;
  logic             fire_nx;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rightHeld_nx = rightHeld;
    leftHeld_nx  = leftHeld;
    spaceHeld_nx = spaceHeld;
    lastDir_nx   = lastDir;
    fire_nx      = 1'b0;

    if (din_new) begin
      // An arriving byte always wins over a coincident timeout.
      cnt_nx   = '0;
      state_nx = IDLE;
      case (state)
        IDLE: begin
          if (din == KC_E0) begin
            state_nx = GOT_E0;
          end else if (din == KC_F0) begin
            state_nx = GOT_F0;
          end else if (din == KC_SPACE) begin
            fire_nx      = !spaceHeld;
            spaceHeld_nx = 1'b1;
          end
        end
        GOT_E0: begin
          if (din == KC_F0) begin
            state_nx = GOT_E0F0;
          end else if (din == KC_E0) begin
            state_nx = GOT_E0;
          end else if (din == KC_RIGHT) begin
            rightHeld_nx = 1'b1;
            if (!rightHeld) lastDir_nx = RIGHT;
          end else if (din == KC_LEFT) begin
            leftHeld_nx = 1'b1;
            if (!leftHeld) lastDir_nx = LEFT;
          end
        end
        GOT_F0: begin
          if (din == KC_SPACE) spaceHeld_nx = 1'b0;
        end
        GOT_E0F0: begin
          if (din == KC_RIGHT) rightHeld_nx = 1'b0;
          else if (din == KC_LEFT) leftHeld_nx = 1'b0;
        end
        default: ;
      endcase
    end else if (state != IDLE) begin
      if (cnt == CNT_LAST) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      cnt       <= '0;
      rightHeld <= 1'b0;
      leftHeld  <= 1'b0;
      spaceHeld <= 1'b0;
      lastDir   <= RIGHT;
      FirePulse <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rightHeld <= rightHeld_nx;
      leftHeld  <= leftHeld_nx;
      spaceHeld <= spaceHeld_nx;
      lastDir   <= lastDir_nx;
      FirePulse <= fire_nx;
    end
  end

  assign RightMove = rightHeld & (!leftHeld | (lastDir == RIGHT));
  assign LeftMove  = leftHeld & (!rightHeld | (lastDir == LEFT));

endmodule

// File: tb/tb_keyboard_move_decoder.sv
// Bench for keyboard_move_decoder: directed vector table, timeout boundary
// sequences and random byte streams checked against a press-order model.
module tb_keyboard_move_decoder;

  localparam int T = 25000;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_new = 1'b0;
  logic       RightMove, LeftMove, FirePulse;

  int n_vec = 0;
  int n_bad = 0;

  keyboard_move_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .resetN(resetN),
    .din(din),
    .din_new(din_new),
    .RightMove(RightMove),
    .LeftMove(LeftMove),
    .FirePulse(FirePulse)
  );

  always #5 clk = ~clk;

  // Reference model: pending prefix bytes as a list, key holds with press times.
  logic [7:0] pend[$];
  int  edge_no = 0;
  int  last_byte_edge = 0;
  bit  m_rh, m_lh, m_sh, m_fire;
  int  m_rt, m_lt;

  function automatic bit m_right();
    return m_rh && (!m_lh || m_rt > m_lt);
  endfunction

  function automatic bit m_left();
    return m_lh && (!m_rh || m_lt > m_rt);
  endfunction

  function automatic void model_step(input logic rn, input logic nw, input logic [7:0] b);
    bit ext, brk;
    edge_no++;
    m_fire = 1'b0;
    if (!rn) begin
      m_rh = 0; m_lh = 0; m_sh = 0;
      pend.delete();
      return;
    end
    if (!nw) return;
    if (pend.size() > 0 && (edge_no - last_byte_edge) > T) pend.delete();
    last_byte_edge = edge_no;
    ext = (pend.size() > 0) && (pend[0] == 8'hE0);
    brk = (pend.size() > 0) && (pend[pend.size()-1] == 8'hF0);
    if (b == 8'hE0) begin
      if (pend.size() == 0) pend.push_back(b);
      else if (!(pend.size() == 1 && ext)) pend.delete();
    end else if (b == 8'hF0) begin
      if (pend.size() == 0 || (pend.size() == 1 && ext)) pend.push_back(b);
      else pend.delete();
    end else begin
      if (ext && b == 8'h74) begin
        if (brk) m_rh = 0;
        else if (!m_rh) begin m_rh = 1; m_rt = edge_no; end
      end else if (ext && b == 8'h6B) begin
        if (brk) m_lh = 0;
        else if (!m_lh) begin m_lh = 1; m_lt = edge_no; end
      end else if (!ext && b == 8'h29) begin
        if (brk) m_sh = 0;
        else begin
          m_fire = !m_sh;
          m_sh = 1;
        end
      end
      pend.delete();
    end
  endfunction

  task automatic tick(input logic rn, input logic nw, input logic [7:0] b);
    @(negedge clk);
    resetN = rn; din_new = nw; din = b;
    model_step(rn, nw, b);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic er, input logic el, input logic ef);
    n_vec++;
    if (RightMove !== er || LeftMove !== el || FirePulse !== ef) begin
      n_bad++;
      $display("FAIL %s @%0t: got R=%b L=%b F=%b, expected R=%b L=%b F=%b",
               name, $time, RightMove, LeftMove, FirePulse, er, el, ef);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_right(), m_left(), m_fire);
  endtask

  typedef struct {
    string      name;
    logic       rn;
    logic       nw;
    logic [7:0] d;
    logic       r, l, f;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] pool[6];

  initial begin
    tbl = '{
      '{"rst0",      0, 0, 8'h00, 0, 0, 0},
      '{"rst1",      0, 0, 8'h00, 0, 0, 0},
      '{"r_e0",      1, 1, 8'hE0, 0, 0, 0},
      '{"r_make",    1, 1, 8'h74, 1, 0, 0},
      '{"r_brk_e0",  1, 1, 8'hE0, 1, 0, 0},
      '{"r_brk_f0",  1, 1, 8'hF0, 1, 0, 0},
      '{"r_brk",     1, 1, 8'h74, 0, 0, 0},
      '{"ov_e0a",    1, 1, 8'hE0, 0, 0, 0},
      '{"ov_r",      1, 1, 8'h74, 1, 0, 0},
      '{"ov_e0b",    1, 1, 8'hE0, 1, 0, 0},
      '{"ov_l",      1, 1, 8'h6B, 0, 1, 0},
      '{"ov_e0c",    1, 1, 8'hE0, 0, 1, 0},
      '{"ov_r_rep",  1, 1, 8'h74, 0, 1, 0},
      '{"ov_e0d",    1, 1, 8'hE0, 0, 1, 0},
      '{"ov_f0",     1, 1, 8'hF0, 0, 1, 0},
      '{"ov_l_brk",  1, 1, 8'h6B, 1, 0, 0},
      '{"ov_e0e",    1, 1, 8'hE0, 1, 0, 0},
      '{"ov_f0b",    1, 1, 8'hF0, 1, 0, 0},
      '{"ov_r_brk",  1, 1, 8'h74, 0, 0, 0},
      '{"fire1",     1, 1, 8'h29, 0, 0, 1},
      '{"fire_rep1", 1, 1, 8'h29, 0, 0, 0},
      '{"fire_rep2", 1, 1, 8'h29, 0, 0, 0},
      '{"fire_idle", 1, 0, 8'h00, 0, 0, 0},
      '{"fire_f0",   1, 1, 8'hF0, 0, 0, 0},
      '{"fire_brk",  1, 1, 8'h29, 0, 0, 0},
      '{"fire2",     1, 1, 8'h29, 0, 0, 1},
      '{"fire2_end", 1, 0, 8'h00, 0, 0, 0},
      '{"sp_f0",     1, 1, 8'hF0, 0, 0, 0},
      '{"sp_brk",    1, 1, 8'h29, 0, 0, 0},
      '{"sp_e0",     1, 1, 8'hE0, 0, 0, 0},
      '{"sp_r",      1, 1, 8'h74, 1, 0, 0},
      '{"sp_f0b",    1, 1, 8'hF0, 1, 0, 0},
      '{"sp_nonext", 1, 1, 8'h74, 1, 0, 0},
      '{"sp_1c",     1, 1, 8'h1C, 1, 0, 0},
      '{"sp_e0b",    1, 1, 8'hE0, 1, 0, 0},
      '{"sp_f0c",    1, 1, 8'hF0, 1, 0, 0},
      '{"sp_rbrk",   1, 1, 8'h74, 0, 0, 0},
      '{"rs_e0",     1, 1, 8'hE0, 0, 0, 0},
      '{"rs_l",      1, 1, 8'h6B, 0, 1, 0},
      '{"rs_e0b",    1, 1, 8'hE0, 0, 1, 0},
      '{"rs_f0",     1, 1, 8'hF0, 0, 1, 0},
      '{"rs_assert", 0, 0, 8'h00, 0, 0, 0},
      '{"rs_6b",     1, 1, 8'h6B, 0, 0, 0},
      '{"rs_idle",   1, 0, 8'h00, 0, 0, 0}
    };

    foreach (tbl[i]) begin
      tick(tbl[i].rn, tbl[i].nw, tbl[i].d);
      check(tbl[i].name, tbl[i].r, tbl[i].l, tbl[i].f);
    end

    // Prefix abandoned after T idle cycles.
    tick(1, 1, 8'hE0);
    for (int i = 0; i < T; i++) tick(1, 0, 8'h00);
    tick(1, 1, 8'h74);
    check("to_expired", 0, 0, 0);
    check_model("to_expired_m");

    // Byte on the last cycle before expiry is still taken in the prefix state.
    tick(1, 1, 8'hE0);
    for (int i = 0; i < T - 1; i++) tick(1, 0, 8'h00);
    tick(1, 1, 8'h74);
    check("to_edge", 1, 0, 0);
    check_model("to_edge_m");
    tick(1, 1, 8'hE0);
    tick(1, 1, 8'hF0);
    tick(1, 1, 8'h74);
    check("to_release", 0, 0, 0);

    pool = '{8'hE0, 8'hF0, 8'h74, 8'h6B, 8'h29, 8'h1C};
    for (int i = 0; i < 3000; i++) begin
      logic rn, nw;
      rn = ($urandom_range(0, 199) != 0);
      nw = ($urandom_range(0, 9) < 7);
      tick(rn, nw, pool[$urandom_range(0, 5)]);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
